// File: rtl/skiroc_sc_sequencer.sv
`timescale 1ns/1ps
// SKIROC slow-control sequencer: fetches config words, shifts them MSB-first into the
// daisy chain on sr_ck, and optionally re-shifts the image while counting readback mismatches.
module skiroc_sc_sequencer #(
    parameter int unsigned NBITS   = 616,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned RST_CYC = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              do_reset,
    input  logic              do_verify,
    input  logic              abort,
    output logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_rdata,
    output logic              sr_ck,
    output logic              sr_in,
    input  logic              sr_out,
    output logic              sr_rstb,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       mismatch_cnt
);

    localparam int unsigned BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned POS_W   = $clog2(WORD_W);
    localparam int unsigned CNT_MAX = (CLK_DIV > RST_CYC) ? CLK_DIV : RST_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FETCH,
        S_LO,
        S_HI,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                pass_q, pass_d;
    logic                verify_q, verify_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sr_ck_q, sr_ck_d;
    logic                sr_in_q, sr_in_d;
    logic                sr_rstb_q, sr_rstb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [15:0]         mcnt_q, mcnt_d;

    // Next-state and datapath update; abort pre-empts all other progress.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        pos_d     = pos_q;
        pass_d    = pass_q;
        verify_d  = verify_q;
        shreg_d   = shreg_q;
        addr_d    = addr_q;
        aborted_d = aborted_q;
        mcnt_d    = mcnt_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        aborted_d = 1'b0;
                        mcnt_d    = '0;
                        verify_d  = do_verify;
                        pass_d    = 1'b0;
                        bit_d     = '0;
                        pos_d     = '0;
                        addr_d    = '0;
                        cnt_d     = '0;
                        state_d   = do_reset ? S_RST : S_FETCH;
                    end
                end
                S_RST: begin
                    if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // cfg_rdata follows cfg_addr by one cycle, so latch on the second cycle.
                S_FETCH: begin
                    if (cnt_q == '0) begin
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                        shreg_d = WORD_W'(cfg_rdata);
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_d   = '0;
                        state_d = S_HI;
                        if (pass_q && (sr_out != shreg_q[WORD_W-1]) && (mcnt_q != 16'hFFFF)) begin
                            mcnt_d = mcnt_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_d = '0;
                        if (bit_q == BIT_W'(NBITS - 1)) begin
                            if (verify_q && !pass_q) begin
                                pass_d  = 1'b1;
                                bit_d   = '0;
                                pos_d   = '0;
                                addr_d  = '0;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_FIN;
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                            if (pos_q == POS_W'(WORD_W - 1)) begin
                                pos_d   = '0;
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = S_FETCH;
                            end else begin
                                pos_d   = pos_q + POS_W'(1);
                                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                                state_d = S_LO;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        sr_ck_d   = (state_d == S_HI);
        sr_in_d   = ((state_d == S_LO) || (state_d == S_HI)) ? shreg_d[WORD_W-1] : 1'b0;
        sr_rstb_d = (state_d != S_RST);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            pos_q     <= '0;
            pass_q    <= 1'b0;
            verify_q  <= 1'b0;
            shreg_q   <= '0;
            addr_q    <= '0;
            sr_ck_q   <= 1'b0;
            sr_in_q   <= 1'b0;
            sr_rstb_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pos_q     <= pos_d;
            pass_q    <= pass_d;
            verify_q  <= verify_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            sr_ck_q   <= sr_ck_d;
            sr_in_q   <= sr_in_d;
            sr_rstb_q <= sr_rstb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign cfg_addr     = addr_q;
    assign sr_ck        = sr_ck_q;
    assign sr_in        = sr_in_q;
    assign sr_rstb      = sr_rstb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_skiroc_sc_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for skiroc_sc_sequencer: a 40-bit chain model and config bank
// feed the DUT; stimulus queues expectations, a negedge monitor checks them.
module tb_skiroc_sc_sequencer;

    localparam int unsigned NB = 40;
    localparam int unsigned AW = 5;
    localparam int unsigned CD = 2;
    localparam int unsigned RC = 4;
    localparam logic [39:0] IMG_A = 40'hA5A50F0FC3;
    localparam logic [39:0] IMG_B = 40'h12345678FF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          do_reset = 1'b0;
    logic          do_verify = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_rdata;
    logic          sr_ck, sr_in, sr_out, sr_rstb, busy, done, aborted;
    logic [15:0]   mismatch_cnt;

    logic [31:0]   mem [0:31];
    logic [39:0]   chain = '0;
    int            rises_tot = 0;
    logic          fault_en = 1'b0;
    int            fault_at = 0;

    skiroc_sc_sequencer #(
        .NBITS(NB), .WORD_W(32), .ADDR_W(AW), .CLK_DIV(CD), .RST_CYC(RC)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .start(start), .do_reset(do_reset),
        .do_verify(do_verify), .abort(abort), .cfg_addr(cfg_addr), .cfg_rdata(cfg_rdata),
        .sr_ck(sr_ck), .sr_in(sr_in), .sr_out(sr_out), .sr_rstb(sr_rstb), .busy(busy),
        .done(done), .aborted(aborted), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cfg_rdata <= mem[cfg_addr];

    // Chain model: shifts on sr_ck rise, cleared by sr_rstb; optional one-shot readback fault.
    always @(posedge sr_ck or negedge sr_rstb) begin
        if (!sr_rstb) begin
            chain <= '0;
        end else begin
            chain     <= {chain[38:0], sr_in};
            rises_tot <= rises_tot + 1;
        end
    end
    assign sr_out = chain[39] | (fault_en && (rises_tot == fault_at));

    typedef struct {
        string       name;
        int          busy_cyc;
        int          rises;
        int          done_n;
        int          rstb_low;
        logic [15:0] mcnt;
        logic        ab;
        logic        chk_model;
        logic [39:0] model;
    } run_t;

    typedef struct {
        string       name;
        logic        timeout;
        logic        chk_out;
        logic [26:0] outs;
        logic        chk_model;
        logic [39:0] model;
    } snap_t;

    run_t  run_q[$];
    snap_t snap_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    end_req = 1'b0;

    function automatic logic [26:0] pack_outs(input logic ck, input logic in_b, input logic rb,
                                              input logic bz, input logic dn, input logic ab,
                                              input logic [4:0] ad, input logic [15:0] mc);
        return {ck, in_b, rb, bz, dn, ab, ad, mc};
    endfunction

    task automatic chk_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: per-run activity counters, checked when busy falls.
    int   m_busy = 0, m_done = 0, m_rises = 0, m_rstb = 0;
    logic prev_busy = 1'b0, prev_ck = 1'b0;

    always @(negedge clk) begin : mon
        snap_t       s;
        run_t        r;
        logic [26:0] act;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            if (s.timeout) begin
                tests++;
                fails++;
                $display("FAIL %s: wait bound expired", s.name);
            end
            if (s.chk_out) begin
                act = pack_outs(sr_ck, sr_in, sr_rstb, busy, done, aborted, cfg_addr, mismatch_cnt);
                tests++;
                if (act !== s.outs) begin
                    fails++;
                    $display("FAIL %s: {ck,in,rstb,busy,done,ab,addr,mcnt} got %h expected %h",
                             s.name, act, s.outs);
                end
            end
            if (s.chk_model) begin
                tests++;
                if (chain !== s.model) begin
                    fails++;
                    $display("FAIL %s: chain got %h expected %h", s.name, chain, s.model);
                end
            end
        end
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_rises = 0; m_rstb = 0;
            prev_busy = 1'b0;
            prev_ck   = 1'b0;
        end else begin
            if (busy) m_busy++;
            if (done) m_done++;
            if (sr_ck && !prev_ck) m_rises++;
            if (!sr_rstb) m_rstb++;
            if (prev_busy && !busy) begin
                if (run_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_run_end: got 1 run end expected 0");
                end else begin
                    r = run_q.pop_front();
                    if (r.busy_cyc >= 0) chk_int({r.name, "_busy_cycles"}, m_busy, r.busy_cyc);
                    chk_int({r.name, "_rises"}, m_rises, r.rises);
                    chk_int({r.name, "_done_pulses"}, m_done, r.done_n);
                    chk_int({r.name, "_rstb_low"}, m_rstb, r.rstb_low);
                    chk_int({r.name, "_mismatch_cnt"}, int'(mismatch_cnt), int'(r.mcnt));
                    chk_int({r.name, "_aborted"}, int'(aborted), int'(r.ab));
                    chk_int({r.name, "_idle_outs"}, int'({sr_ck, sr_in, sr_rstb}), 1);
                    if (r.chk_model) begin
                        tests++;
                        if (chain !== r.model) begin
                            fails++;
                            $display("FAIL %s_chain: got %h expected %h", r.name, chain, r.model);
                        end
                    end
                end
                m_busy = 0; m_done = 0; m_rises = 0; m_rstb = 0;
            end
            prev_busy = busy;
            prev_ck   = sr_ck;
        end
        if (end_req) begin
            chk_int("pending_runs", run_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic push_outs(input string nm, input logic ck, input logic in_b, input logic rb,
                             input logic bz, input logic dn, input logic ab,
                             input logic [4:0] ad, input logic [15:0] mc);
        snap_t s;
        s.name = nm; s.timeout = 1'b0; s.chk_out = 1'b1;
        s.outs = pack_outs(ck, in_b, rb, bz, dn, ab, ad, mc);
        s.chk_model = 1'b0; s.model = '0;
        snap_q.push_back(s);
    endtask

    task automatic push_model(input string nm, input logic [39:0] m);
        snap_t s;
        s.name = nm; s.timeout = 1'b0; s.chk_out = 1'b0; s.outs = '0;
        s.chk_model = 1'b1; s.model = m;
        snap_q.push_back(s);
    endtask

    task automatic push_timeout(input string nm);
        snap_t s;
        s.name = nm; s.timeout = 1'b1; s.chk_out = 1'b0; s.outs = '0;
        s.chk_model = 1'b0; s.model = '0;
        snap_q.push_back(s);
    endtask

    task automatic push_run(input string nm, input int bc, input int rs, input int dn,
                            input int rl, input logic [15:0] mc, input logic ab,
                            input logic cm, input logic [39:0] m);
        run_t r;
        r.name = nm; r.busy_cyc = bc; r.rises = rs; r.done_n = dn; r.rstb_low = rl;
        r.mcnt = mc; r.ab = ab; r.chk_model = cm; r.model = m;
        run_q.push_back(r);
    endtask

    task automatic pulse_start(input logic rs, input logic vf);
        @(posedge clk); #1;
        start = 1'b1; do_reset = rs; do_verify = vf;
        @(posedge clk); #1;
        start = 1'b0; do_reset = 1'b0; do_verify = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) push_timeout(nm);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic [31:0] w0, input logic [31:0] w1);
        mem[0] = w0;
        mem[1] = w1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        set_mem(32'hA5A5_0F0F, 32'hC35A_1234);

        repeat (3) @(posedge clk);
        #1;
        push_outs("reset_state", 0, 0, 1, 0, 0, 0, 5'd0, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        push_run("plain_a", NB*2*CD + 2*2 + 1, 40, 1, 0, 16'd0, 1'b0, 1'b1, IMG_A);
        pulse_start(1'b0, 1'b0);
        wait_idle("plain_a");
        push_outs("plain_a_idle", 0, 0, 1, 0, 0, 0, 5'd1, 16'd0);

        push_run("verify_a", 329, 80, 1, 0, 16'd0, 1'b0, 1'b1, IMG_A);
        pulse_start(1'b0, 1'b1);
        wait_idle("verify_a");

        fault_en = 1'b1;
        fault_at = rises_tot + 57;
        push_run("verify_fault", 329, 80, 1, 0, 16'd1, 1'b0, 1'b1, IMG_A);
        pulse_start(1'b0, 1'b1);
        wait_idle("verify_fault");
        fault_en = 1'b0;
        push_outs("fault_cnt_held", 0, 0, 1, 0, 0, 0, 5'd1, 16'd1);

        set_mem(32'h1234_5678, 32'hFF00_0000);
        push_run("plain_b", 165, 40, 1, 0, 16'd0, 1'b0, 1'b1, IMG_B);
        pulse_start(1'b0, 1'b0);
        wait_idle("plain_b");

        set_mem(32'hA5A5_0F0F, 32'hC35A_1234);
        push_run("reset_a", 169, 40, 1, 4, 16'd0, 1'b0, 1'b1, IMG_A);
        pulse_start(1'b1, 1'b0);
        push_outs("rst_active", 0, 0, 0, 1, 0, 0, 5'd0, 16'd0);
        n = 0;
        while (!sr_rstb && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sr_rstb) push_timeout("rst_release");
        push_model("rst_clears_chain", 40'h0);
        wait_idle("reset_a");

        push_run("restart_ignored", 165, 40, 1, 0, 16'd0, 1'b0, 1'b1, IMG_A);
        pulse_start(1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        start = 1'b1; do_verify = 1'b1; do_reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; do_verify = 1'b0; do_reset = 1'b0;
        wait_idle("restart_ignored");

        push_run("abort_run", -1, 20, 0, 0, 16'd0, 1'b1, 1'b0, 40'h0);
        base = rises_tot;
        pulse_start(1'b0, 1'b1);
        n = 0;
        while ((rises_tot != base + 20) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (rises_tot != base + 20) push_timeout("abort_wait");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        push_outs("abort_idle", 0, 0, 1, 0, 0, 1, 5'd0, 16'd0);
        wait_idle("abort_run");

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        push_outs("start_abort_idle", 0, 0, 1, 0, 0, 1, 5'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        push_outs("stay_idle", 0, 0, 1, 0, 0, 1, 5'd0, 16'd0);

        pulse_start(1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        push_outs("reset_midshift", 0, 0, 1, 0, 0, 0, 5'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        set_mem(32'h1234_5678, 32'hFF00_0000);
        push_run("verify_b", 329, 80, 1, 0, 16'd0, 1'b0, 1'b1, IMG_B);
        pulse_start(1'b0, 1'b1);
        wait_idle("verify_b");

        end_req = 1'b1;
    end

endmodule
